// File: rtl/diff_core_pkg.sv
// Shared types and constants for the diff core psum sequencing logic.
// Holds the psum sequencer FSM states, the drain length and a small mod-3 helper.
package diff_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WAIT_WB,
        DONE
    } psum_seq_state_t;

    localparam int PSUM_SEQ_DRAIN = 2;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/psum_seq_cnt.sv
// Cascaded w/h/c wrap counter for the psum sequencer.
// Ports: clk, rst, clr (sync clear), en (advance), w_num/h_num/c_num (limits),
//        w_cnt/h_cnt/c_cnt (indices), w_last/h_last/c_last (carry flags).
module psum_seq_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] w_num,
    input  logic [CW-1:0] h_num,
    input  logic [CW-1:0] c_num,
    output logic [CW-1:0] w_cnt,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] c_cnt,
    output logic          w_last,
    output logic          h_last,
    output logic          c_last
);

    localparam logic [CW-1:0] ONE = CW'(1);

    // Limits are at least 1 while counting, so num-1 never underflows.
    assign w_last = (w_cnt == w_num - ONE);
    assign h_last = (h_cnt == h_num - ONE);
    assign c_last = (c_cnt == c_num - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt <= '0;
            h_cnt <= '0;
            c_cnt <= '0;
        end else if (clr) begin
            w_cnt <= '0;
            h_cnt <= '0;
            c_cnt <= '0;
        end else if (en) begin
            if (w_last) begin
                w_cnt <= '0;
                if (h_last) begin
                    h_cnt <= '0;
                    c_cnt <= c_last ? '0 : c_cnt + ONE;
                end else begin
                    h_cnt <= h_cnt + ONE;
                end
            end else begin
                w_cnt <= w_cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/psum_seq_ctrl.sv
// Psum sequencer: walks w/h/c coordinates while the PE array has data, then
// drains, waits for write-back and pulses done.
// Ports: clk, rst, start, abort, w_num/h_num/c_num, kernal_mode, pe_valid_i,
//        wb_stall_i, wb_finish_i -> psum_almost_valid, psum_valid, count_w/h/c,
//        count_3, tick_tock, is_even_even_row, busy, done, cfg_err.
module psum_seq_ctrl
    import diff_core_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] w_num,
    input  logic [CW-1:0] h_num,
    input  logic [CW-1:0] c_num,
    input  logic          kernal_mode,
    input  logic          pe_valid_i,
    input  logic          wb_stall_i,
    input  logic          wb_finish_i,
    output logic          psum_almost_valid,
    output logic          psum_valid,
    output logic [CW-1:0] count_w,
    output logic [CW-1:0] count_h,
    output logic [CW-1:0] count_c,
    output logic [1:0]    count_3,
    output logic          tick_tock,
    output logic          is_even_even_row,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [1:0] DRAIN_LAST = 2'(PSUM_SEQ_DRAIN - 1);

    psum_seq_state_t state;
    psum_seq_state_t state_nxt;

    logic [CW-1:0] w_cfg;
    logic [CW-1:0] h_cfg;
    logic [CW-1:0] c_cfg;
    logic          k_cfg;

    logic [1:0]    drain_cnt;
    logic          wb_seen;

    logic [CW-1:0] w_idx;
    logic [CW-1:0] h_idx;
    logic [CW-1:0] c_idx;
    logic          w_last;
    logic          h_last;
    logic          c_last;

    logic          cfg_nz;
    logic          start_ok;
    logic          cfg_bad;
    logic          issue;
    logic          row_wrap;
    logic          chan_wrap;
    logic          last_word;
    logic          ee_nxt;
    logic [CW:0]   cc_inc;
    logic [CW-1:0] cc_nxt;

    logic [CW-1:0] cc_q;
    logic [1:0]    c3_q;
    logic          tt_q;
    logic          ee_q;
    logic          pv_q;
    logic          err_q;
    logic          busy_q;
    logic          done_q;
    logic          busy_d;
    logic          done_d;

    assign cfg_nz   = (w_num != '0) && (h_num != '0) && (c_num != '0);
    assign start_ok = (state == IDLE) && start && !abort && cfg_nz;
    assign cfg_bad  = (state == IDLE) && start && !abort && !cfg_nz;

    assign issue     = (state == RUN) && pe_valid_i && !wb_stall_i;
    assign row_wrap  = issue && w_last;
    assign chan_wrap = row_wrap && h_last;
    assign last_word = chan_wrap && c_last;

    // Bit 1 of (row+1) is row[1]^row[0]; a row wrap lands on row 0.
    assign ee_nxt = k_cfg && !h_last && (h_idx[1] ^ h_idx[0]);

    // count_c runs one channel ahead, wrapping at the latched channel count.
    assign cc_inc = {1'b0, cc_q} + {{CW{1'b0}}, 1'b1};
    assign cc_nxt = (cc_inc == {1'b0, c_cfg}) ? '0 : cc_inc[CW-1:0];

    psum_seq_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort || start_ok),
        .en     (issue),
        .w_num  (w_cfg),
        .h_num  (h_cfg),
        .c_num  (c_cfg),
        .w_cnt  (w_idx),
        .h_cnt  (h_idx),
        .c_cnt  (c_idx),
        .w_last (w_last),
        .h_last (h_last),
        .c_last (c_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start_ok) state_nxt = RUN;
                RUN:     if (last_word) state_nxt = DRAIN;
                DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = WAIT_WB;
                WAIT_WB: if (wb_seen || wb_finish_i) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Decoded from the next state so busy/done come straight from flops.
    always_comb begin
        busy_d = (state_nxt != IDLE);
        done_d = (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_cnt <= '0;
            wb_seen   <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            drain_cnt <= (state == DRAIN && !abort) ? drain_cnt + 2'd1 : 2'd0;
            if (abort || state_nxt == IDLE) begin
                wb_seen <= 1'b0;
            end else if ((state == DRAIN || state == WAIT_WB) && wb_finish_i) begin
                wb_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cfg <= '0;
            h_cfg <= '0;
            c_cfg <= '0;
            k_cfg <= 1'b0;
            cc_q  <= '0;
            c3_q  <= '0;
            tt_q  <= 1'b0;
            ee_q  <= 1'b0;
            pv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pv_q  <= issue;
            err_q <= cfg_bad;
            if (abort) begin
                cc_q <= '0;
                c3_q <= '0;
                tt_q <= 1'b0;
                ee_q <= 1'b0;
            end else if (start_ok) begin
                w_cfg <= w_num;
                h_cfg <= h_num;
                c_cfg <= c_num;
                k_cfg <= kernal_mode;
                cc_q  <= (c_num == CW'(1)) ? '0 : CW'(1);
                c3_q  <= '0;
                tt_q  <= 1'b0;
                ee_q  <= 1'b0;
            end else if (last_word) begin
                cc_q <= '0;
                c3_q <= '0;
                tt_q <= 1'b0;
                ee_q <= 1'b0;
            end else if (issue) begin
                c3_q <= row_wrap ? 2'd0 : mod3_inc(c3_q);
                if (row_wrap) begin
                    tt_q <= !tt_q;
                    ee_q <= ee_nxt;
                end
                if (chan_wrap) begin
                    cc_q <= cc_nxt;
                end
            end
        end
    end

    assign psum_almost_valid = issue;
    assign psum_valid        = pv_q;
    assign count_w           = w_idx;
    assign count_h           = h_idx;
    assign count_c           = cc_q;
    assign count_3           = c3_q;
    assign tick_tock         = tt_q;
    assign is_even_even_row  = ee_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign cfg_err           = err_q;

    logic unused_c_idx;
    assign unused_c_idx = ^c_idx;

endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Directed self-checking bench for psum_seq_ctrl.
// Drives at posedge+1, samples at negedge.
module tb_psum_seq_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] w_num;
    logic [CW-1:0] h_num;
    logic [CW-1:0] c_num;
    logic          kernal_mode;
    logic          pe_valid_i;
    logic          wb_stall_i;
    logic          wb_finish_i;
    logic          psum_almost_valid;
    logic          psum_valid;
    logic [CW-1:0] count_w;
    logic [CW-1:0] count_h;
    logic [CW-1:0] count_c;
    logic [1:0]    count_3;
    logic          tick_tock;
    logic          is_even_even_row;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    psum_seq_ctrl #(.CW(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .w_num             (w_num),
        .h_num             (h_num),
        .c_num             (c_num),
        .kernal_mode       (kernal_mode),
        .pe_valid_i        (pe_valid_i),
        .wb_stall_i        (wb_stall_i),
        .wb_finish_i       (wb_finish_i),
        .psum_almost_valid (psum_almost_valid),
        .psum_valid        (psum_valid),
        .count_w           (count_w),
        .count_h           (count_h),
        .count_c           (count_c),
        .count_3           (count_3),
        .tick_tock         (tick_tock),
        .is_even_even_row  (is_even_even_row),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int w, input int h, input int c, input bit km);
        w_num       = CW'(w);
        h_num       = CW'(h);
        c_num       = CW'(c);
        kernal_mode = km;
        start       = 1'b1;
        step();
        start       = 1'b0;
        // Scramble config: must be ignored once the frame has started.
        w_num       = 8'd9;
        h_num       = 8'd0;
        c_num       = 8'd7;
        kernal_mode = ~km;
    endtask

    // Runs a full frame; stalls when cyc % smod == 1 (smod=0: never).
    task automatic run_frame(input int w, input int h, input int c,
                             input bit km, input int smod, input bit sid);
        int n;
        int cyc;
        int tot;
        int ww;
        int r;
        int ch;
        bit iss;
        bit prev;
        n    = 0;
        cyc  = 0;
        prev = 1'b0;
        tot  = w * h * c;
        start_frame(w, h, c, km);
        while (n < tot && cyc < 4000) begin
            wb_stall_i = (smod > 0) && (cyc % smod == 1);
            iss = !wb_stall_i;
            @(negedge clk);
            chk("iss", psum_almost_valid, iss);
            chk("pv", psum_valid, prev);
            ww = n % w;
            r  = (n / w) % h;
            ch = n / (w * h);
            chk("cw", count_w, ww);
            chk("ch", count_h, r);
            chk("cc", count_c, (ch + 1) % c);
            chk("c3", count_3, ww % 3);
            chk("ee", is_even_even_row, km ? (r >> 1) & 1 : 0);
            if (ch == 0) chk("tt", tick_tock, r & 1);
            if (iss) n++;
            prev = iss;
            step();
            cyc++;
        end
        wb_stall_i = 1'b0;
        chk("words", n, tot);
        for (int j = 0; j < 4; j++) begin
            start = sid && (j == 3);
            @(negedge clk);
            chk("post_iss", psum_almost_valid, 0);
            chk("post_busy", busy, 1);
            chk("post_done", done, (j == 3) ? 1 : 0);
            if (j == 0) chk("post_pv", psum_valid, 1);
            step();
        end
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("end_busy", busy, 0);
            chk("end_done", done, 0);
            step();
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        w_num       = '0;
        h_num       = '0;
        c_num       = '0;
        kernal_mode = 1'b0;
        pe_valid_i  = 1'b1;
        wb_stall_i  = 1'b0;
        wb_finish_i = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_iss", psum_almost_valid, 0);
        chk("rst_pv", psum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_cw", count_w, 0);
        chk("rst_ch", count_h, 0);
        chk("rst_cc", count_c, 0);
        chk("rst_c3", count_3, 0);
        chk("rst_tt", tick_tock, 0);
        chk("rst_ee", is_even_even_row, 0);
        step();
        rst = 1'b0;
        step();

        run_frame(4, 2, 1, 1'b0, 0, 1'b0);
        run_frame(3, 4, 2, 1'b1, 0, 1'b0);
        run_frame(5, 1, 1, 1'b0, 2, 1'b0);
        run_frame(255, 1, 1, 1'b0, 0, 1'b0);

        // Zero height: error pulse, no frame.
        w_num = 8'd4;
        h_num = 8'd0;
        c_num = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", cfg_err, 1);
        chk("err_busy", busy, 0);
        chk("err_iss", psum_almost_valid, 0);
        step();
        @(negedge clk);
        chk("err_clr", cfg_err, 0);
        chk("err_busy2", busy, 0);
        step();

        // Abort while issuing word index 5 of a 4x4 frame.
        start_frame(4, 4, 1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        abort = 1'b1;
        @(negedge clk);
        chk("ab_iss", psum_almost_valid, 1);
        chk("ab_cw", count_w, 1);
        chk("ab_ch", count_h, 1);
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_iss2", psum_almost_valid, 0);
        chk("ab_cw2", count_w, 0);
        chk("ab_ch2", count_h, 0);
        chk("ab_pv", psum_valid, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            chk("ab_done", done, 0);
        end
        step();
        run_frame(4, 4, 1, 1'b0, 0, 1'b0);

        // Reset while waiting for write-back.
        wb_finish_i = 1'b0;
        start_frame(2, 1, 1, 1'b0);
        for (int i = 0; i < 7; i++) step();
        @(negedge clk);
        chk("wb_busy", busy, 1);
        chk("wb_done", done, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        step();
        rst = 1'b0;
        wb_finish_i = 1'b1;
        step();
        wb_finish_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_done", done, 0);
            chk("rst_mid_idle", busy, 0);
            step();
        end
        wb_finish_i = 1'b1;
        run_frame(3, 2, 1, 1'b0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
